hazard_forward_unit: RTL
========================

# hazard_forward_unit

Generates the operand-forwarding selects and the load-use stall for the 5-stage pipeline: the producer side of the `forward_a`/`forward_b` selects the EX-stage operand muxes consume ahead of `alu`. It sits beside the ID/EX pipeline register. It tracks the destination of every in-flight instruction in EX, MEM and WB in an internal 3-entry shadow pipeline. From that it decides, at ID time, where each source operand must come from once the instruction reaches EX.

## Interface
- No parameters. Register index width is fixed at 5 and x0 is hardwired zero.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` input 5: ID source registers.
- `id_uses_rs1`, `id_uses_rs2` input 1: the instruction actually reads that source.
- `id_rd` input 5: ID destination register.
- `id_reg_write` input 1: the ID instruction writes `id_rd`.
- `id_mem_read` input 1: the ID instruction is a load.
- `flush_id` input 1: the ID instruction is killed (taken branch) and must enter EX as a bubble.
- `stall` output 1: hold PC and IF/ID; insert a bubble into EX this cycle.
- `forward_a`, `forward_b` output 2: operand select for the instruction currently in EX. Encoding: 00 register file, 10 MEM-stage result, 01 WB-stage result.
- `stall_count` output 32: saturating count of cycles with `stall`=1.

## Operation
- The shadow pipeline has entries EX, MEM and WB, each holding {valid, rd, reg_write, is_load}.
- Every cycle: WB←MEM, MEM←EX.
- EX←ID entry only if `id_valid` & ~`stall` & ~`flush_id`. Otherwise EX←bubble (valid=0).
- An entry "produces r" iff valid & reg_write & rd==r & r!=0.
- Forward decision, made at ID for each used source r and registered into `forward_a`/`forward_b` on the edge the instruction enters EX:
  - EX entry produces r → 10 (it will be in MEM).
  - else MEM entry produces r → 01 (it will be in WB).
  - else 00.
  - Unused source, bubble, or flushed instruction → 00.
- Load-use hazard: EX entry is_load and produces a used ID source.
- `stall` = id_valid & ~flush_id & hazard. It is combinational and valid in the same cycle.
- During a stall the registered forward selects load 00, because a bubble enters EX. Next cycle the load is in MEM and the decision resolves to 01.
- A WB-stage producer needs no forwarding: the register file is write-through.
- Simultaneous `flush_id` and hazard: flush wins, `stall`=0, and a bubble enters EX.
- `stall_count` increments on every clock where `stall`=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset (async assert, sync release): all entries invalid, `forward_a`=`forward_b`=00, `stall`=0, `stall_count`=0.
- Reset mid-operation discards all in-flight state immediately.
- `forward_*` are registered: they are valid for the whole cycle the instruction occupies EX, one cycle after its ID cycle.
- `stall` has zero latency from ID inputs and shadow state. It has no combinational path from `forward_*`.
- Load-use costs exactly one stall cycle with `FWD_EN`.
- `stall_count` updates one cycle after the stalled cycle.

## Configuration
- `HAZARD_FWD_EN` defined: behaviour as above.
- `HAZARD_FWD_EN` undefined:
  - `forward_a` and `forward_b` are constant 00.
  - Hazard is redefined: any used ID source produced by the EX or MEM entry, regardless of load.
  - RAW stalls last until the producer reaches WB: 2 cycles behind an EX producer, 1 cycle behind a MEM producer.
  - Flush priority and `stall_count` are unchanged.

## Test plan
- Reset: hold `rst_n`=0 with random ID inputs → `stall`=0, `forward_*`=00, `stall_count`=0. Release it, then issue `add x5` followed by `add x6,x5,x5`.
  - → second instruction in EX sees `forward_a`=`forward_b`=10.
- Distance 2: `add x5`, `nop`, `sub x7,x5,x1` → sub in EX sees `forward_a`=01, `forward_b`=00.
  - If x1 is written by the nop-slot instruction instead, `forward_b`=10.
- Load-use: `ld x8`, then `add x9,x8,x2` → `stall`=1 for exactly one cycle; a bubble enters EX; the add in EX sees `forward_a`=01; `stall_count`=1.
- x0 and unused-source rules:
  - `add x0` then `add x3,x0,x0` → no forward, no stall.
  - `ld x4` then a consumer with `id_uses_rs1`=0 on rs1=x4 → no stall.
- Flush: `ld x8`, then `add x9,x8,x8` with `flush_id`=1 → `stall`=0; the add never enters EX; the next instruction reading x9 gets 00.
- `HAZARD_FWD_EN` undefined: `add x5`, then `or x6,x5,x0` → `stall`=1 for 2 cycles, `forward_*` always 00, `stall_count`=2.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Operand-forward selects and load-use stall for the 5-stage pipeline, tracking EX/MEM/WB destinations.
// Define HAZARD_FWD_EN to enable forwarding; without it every RAW hazard stalls until the producer reaches WB.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush_id,
  output logic        stall,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [31:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } entry_t;

  entry_t      ex_q, mem_q, wb_q, ex_d;
  logic        hazard;
  logic        issue;
  logic [31:0] stall_count_q, stall_count_d;
  logic        unused_shadow;

  function automatic logic produces(input entry_t e, input logic [4:0] r);
    return e.valid & e.reg_write & (e.rd == r) & (r != 5'd0);
  endfunction

  // WB is kept for completeness of the shadow pipe; the write-through register file means nothing reads it.
  assign unused_shadow = ^{wb_q, mem_q.is_load, ex_q.is_load};

`ifdef HAZARD_FWD_EN
  logic [1:0] forward_a_q, forward_a_d;
  logic [1:0] forward_b_q, forward_b_d;

  function automatic logic [1:0] fwdSelect(input entry_t ex, input entry_t mem,
                                           input logic used, input logic [4:0] r);
    if (!used)               return 2'b00;
    else if (produces(ex, r))  return 2'b10;
    else if (produces(mem, r)) return 2'b01;
    else                       return 2'b00;
  endfunction

  // Only a load still in EX has no result to forward when the consumer reaches EX.
  always_comb begin
    hazard = ex_q.is_load &
             ((id_uses_rs1 & produces(ex_q, id_rs1)) |
              (id_uses_rs2 & produces(ex_q, id_rs2)));
  end

  always_comb begin
    forward_a_d = 2'b00;
    forward_b_d = 2'b00;
    if (issue) begin
      forward_a_d = fwdSelect(ex_q, mem_q, id_uses_rs1, id_rs1);
      forward_b_d = fwdSelect(ex_q, mem_q, id_uses_rs2, id_rs2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      forward_a_q <= 2'b00;
      forward_b_q <= 2'b00;
    end else begin
      forward_a_q <= forward_a_d;
      forward_b_q <= forward_b_d;
    end
  end

  assign forward_a = forward_a_q;
  assign forward_b = forward_b_q;
`else
  always_comb begin
    hazard = (id_uses_rs1 & (produces(ex_q, id_rs1) | produces(mem_q, id_rs1))) |
             (id_uses_rs2 & (produces(ex_q, id_rs2) | produces(mem_q, id_rs2)));
  end

  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  // A flushed ID instruction never stalls; it simply enters EX as a bubble.
  always_comb begin
    stall         = id_valid & ~flush_id & hazard;
    issue         = id_valid & ~stall & ~flush_id;
    ex_d          = '0;
    stall_count_d = stall_count_q;
    if (issue) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = id_mem_read;
    end
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= 32'd0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= ex_q;
      wb_q          <= mem_q;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
